icache_ctrl: RTL

Direct-mapped instruction-cache controller between the fetch stage and the shared instruction memory. It looks up fetch addresses in an internal tag/data array and returns hits with one-cycle latency. On a miss it stalls fetch through `busy_o`, refills the whole line from backing memory over a request/grant/rvalid handshake, then returns the requested word. It also owns cache invalidation (flush) and hit/miss counters for the benches.

---
 rtl/icache_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped instruction cache controller with line refill
// Hits are looked up in the cycle after accept; misses stall fetch and refill the whole line.
module icache_ctrl #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_addr_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        busy_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [29:0]       addr_q;
  logic              lookup_q;
  logic [OFF_W-1:0]  beat_q;
  logic              flush_pend_q;
  logic [31:0]       hit_cnt_q, miss_cnt_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q  [NUM_LINES];
  logic [31:0]       data_q [NUM_LINES][LINE_WORDS];

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              line_hit, lookup_hit, lookup_miss;
  logic              accept, fill_beat, fill_last, flush_now;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^fetch_addr_i[1:0];

  assign off      = addr_q[OFF_W-1:0];
  assign idx      = addr_q[OFF_W +: IDX_W];
  assign tag      = addr_q[29 -: TAG_W];
  assign line_hit = valid_q[idx] && (tag_q[idx] == tag);

  always_comb begin
    state_d       = state_q;
    busy_o        = 1'b0;
    instr_valid_o = 1'b0;
    mem_req_o     = 1'b0;
    lookup_hit    = 1'b0;
    lookup_miss   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lookup_q) begin
          if (line_hit) begin
            lookup_hit    = 1'b1;
            instr_valid_o = 1'b1;
          end else begin
            lookup_miss = 1'b1;
            busy_o      = 1'b1;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        busy_o    = 1'b1;
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = S_DATA;
      end
      S_DATA: begin
        busy_o = 1'b1;
        if (mem_rvalid_i && beat_q == LAST_BEAT) state_d = S_RESP;
      end
      S_RESP: begin
        instr_valid_o = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept    = fetch_req_i && !busy_o;
  assign fill_beat = (state_q == S_DATA) && mem_rvalid_i;
  assign fill_last = fill_beat && (beat_q == LAST_BEAT);
  // A flush seen during the burst is deferred until the response has been delivered.
  assign flush_now = (flush_i && (state_q == S_IDLE || state_q == S_RESP)) ||
                     (flush_pend_q && state_q == S_RESP);

  assign instr_o    = instr_valid_o ? data_q[idx][off] : 32'h0;
  assign mem_addr_o = mem_req_o ? {addr_q[29:OFF_W], {(OFF_W + 2){1'b0}}} : 32'h0;
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      lookup_q     <= 1'b0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      valid_q      <= '0;
    end else begin
      state_q  <= state_d;
      lookup_q <= accept;
      if (accept) addr_q <= fetch_addr_i[31:2];
      if (fill_beat) beat_q <= beat_q + 1'b1;
      if (lookup_hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (lookup_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (flush_i && (state_q == S_REQ || state_q == S_DATA)) flush_pend_q <= 1'b1;
      else if (state_q == S_RESP) flush_pend_q <= 1'b0;
      if (flush_now) valid_q <= '0;
      else if (fill_last) valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_beat) data_q[idx][beat_q] <= mem_rdata_i;
    if (fill_last) tag_q[idx] <= tag;
  end

endmodule
